// File: rtl/eth_rx_parser_if.sv
// +----------------------------------------------------------------------------+
// | eth_rx_parser_if                                                            |
// | FIFO-side signals of eth_rx_parser: FWFT input FIFO pop side and output    |
// | FIFO push side. master = parser, slave = FIFOs / environment.               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface eth_rx_parser_if;
  logic [7:0] in_dout;
  logic       in_rd_sof;
  logic       in_rd_eof;
  logic       in_empty;
  logic       in_rd_en;
  logic [7:0] out_din;
  logic       out_wr_sof;
  logic       out_wr_eof;
  logic       out_wr_en;
  logic       out_full;

  modport master (
    input  in_dout, in_rd_sof, in_rd_eof, in_empty, out_full,
    output in_rd_en, out_din, out_wr_sof, out_wr_eof, out_wr_en
  );

  modport slave (
    output in_dout, in_rd_sof, in_rd_eof, in_empty, out_full,
    input  in_rd_en, out_din, out_wr_sof, out_wr_eof, out_wr_en
  );
endinterface

`default_nettype wire

// File: rtl/eth_rx_parser.sv
// +----------------------------------------------------------------------------+
// | eth_rx_parser                                                               |
// | Strips the 14-byte MAC header, filters on EtherType and forwards the L3    |
// | payload re-framed with sof/eof. Optional macro ETH_VLAN_SKIP_EN skips one  |
// | 802.1Q tag and compares the inner EtherType instead.                        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module eth_rx_parser #(
  parameter logic [15:0] ETHER_TYPE = 16'h0800,
  parameter int          CNT_W      = 16
) (
  input  wire logic             clock,
  input  wire logic             reset,
  eth_rx_parser_if.master       fifo,
  output logic [47:0]           dst_mac,
  output logic [47:0]           src_mac,
  output logic [15:0]           ether_type,
  output logic [CNT_W-1:0]      fwd_cnt,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic [CNT_W-1:0]      err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_DROP    = 2'd3
  } state_t;

  localparam logic [15:0] c_VLAN_TPID = 16'h8100;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_first;

  logic        w_pop;
  logic        w_sof;
  logic        w_eof;
  logic [7:0]  w_byte;
  logic [15:0] w_type;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    fifo.in_rd_en = 1'b0;
    if (reset) begin
      if (r_state == S_PAYLOAD)
        fifo.in_rd_en = !fifo.in_empty && !fifo.out_full;
      else
        fifo.in_rd_en = !fifo.in_empty;
    end
  end

  assign w_pop  = fifo.in_rd_en;
  assign w_sof  = fifo.in_rd_sof;
  assign w_eof  = fifo.in_rd_eof;
  assign w_byte = fifo.in_dout;
  // High type byte is already registered; low byte is the one being popped.
  assign w_type = {ether_type[15:8], w_byte};

  assign fifo.out_din    = w_byte;
  assign fifo.out_wr_eof = w_eof & reset;
  assign fifo.out_wr_en  = w_pop & (r_state == S_PAYLOAD);
  assign fifo.out_wr_sof = fifo.out_wr_en & r_first;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 5'd0;
      r_first    <= 1'b0;
      dst_mac    <= 48'd0;
      src_mac    <= 48'd0;
      ether_type <= 16'd0;
      fwd_cnt    <= '0;
      drop_cnt   <= '0;
      err_cnt    <= '0;
    end else if (w_pop) begin
      case (r_state)
        S_IDLE: begin
          if (!w_sof) begin
            err_cnt <= sat_inc(err_cnt);
          end else begin
            dst_mac[47:40] <= w_byte;
            r_cnt          <= 5'd1;
            if (w_eof)
              drop_cnt <= sat_inc(drop_cnt);
            else
              r_state  <= S_HEADER;
          end
        end

        S_HEADER: begin
          r_cnt <= r_cnt + 5'd1;
          if (w_sof)
            err_cnt <= sat_inc(err_cnt);
          case (r_cnt)
            5'd1:  dst_mac[39:32]    <= w_byte;
            5'd2:  dst_mac[31:24]    <= w_byte;
            5'd3:  dst_mac[23:16]    <= w_byte;
            5'd4:  dst_mac[15:8]     <= w_byte;
            5'd5:  dst_mac[7:0]      <= w_byte;
            5'd6:  src_mac[47:40]    <= w_byte;
            5'd7:  src_mac[39:32]    <= w_byte;
            5'd8:  src_mac[31:24]    <= w_byte;
            5'd9:  src_mac[23:16]    <= w_byte;
            5'd10: src_mac[15:8]     <= w_byte;
            5'd11: src_mac[7:0]      <= w_byte;
            5'd12: ether_type[15:8]  <= w_byte;
            5'd13: ether_type[7:0]   <= w_byte;
`ifdef ETH_VLAN_SKIP_EN
            5'd16: ether_type[15:8]  <= w_byte;
            5'd17: ether_type[7:0]   <= w_byte;
`endif
            default: ;
          endcase
          // Any eof still inside the header is a runt.
          if (w_eof) begin
            drop_cnt <= sat_inc(drop_cnt);
            r_state  <= S_IDLE;
          end else if (r_cnt == 5'd13) begin
            if (w_type == ETHER_TYPE) begin
              r_state <= S_PAYLOAD;
              r_first <= 1'b1;
`ifdef ETH_VLAN_SKIP_EN
            end else if (w_type == c_VLAN_TPID) begin
              r_state <= S_HEADER;
`endif
            end else begin
              r_state <= S_DROP;
            end
`ifdef ETH_VLAN_SKIP_EN
          end else if (r_cnt == 5'd17) begin
            if (w_type == ETHER_TYPE) begin
              r_state <= S_PAYLOAD;
              r_first <= 1'b1;
            end else begin
              r_state <= S_DROP;
            end
`endif
          end
        end

        S_PAYLOAD: begin
          r_first <= 1'b0;
          if (w_sof)
            err_cnt <= sat_inc(err_cnt);
          if (w_eof) begin
            fwd_cnt <= sat_inc(fwd_cnt);
            r_state <= S_IDLE;
          end
        end

        S_DROP: begin
          if (w_eof) begin
            drop_cnt <= sat_inc(drop_cnt);
            r_state  <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifndef ETH_VLAN_SKIP_EN
  logic w_unused;
  assign w_unused = ^c_VLAN_TPID;
`endif

endmodule

`default_nettype wire
